// File: rtl/regfile_mp_sb.sv
// ----------------------------------------------------------------------------
// regfile_mp_sb
//
// Multi-port integer register file with a busy scoreboard, used by the
// pipelined core.
// - NRD combinational read ports.
// - Two write-back ports. Port B has priority over port A.
// - Optional same-cycle forwarding from a write to a read (BYPASS).
// - One busy bit per register. A bit is set when an instruction is issued
//   with that destination, and cleared when the result is written back.
// - Register 0 always reads as zero and is never busy.
//
// Ports
//   clk       : clock; all state updates on the rising edge
//   rst       : synchronous, active-high reset (clears data and busy bits)
//   rs_addr   : NRD packed read addresses, port i at [i*ADDR_W +: ADDR_W]
//   rs_data   : NRD packed read data,      port i at [i*XLEN   +: XLEN]
//   rs_busy   : per read port, the addressed register is reserved
//   wa_en/wa_addr/wa_data : write-back port A
//   wb_en/wb_addr/wb_data : write-back port B (wins over A on the same address)
//   rsv_en/rsv_addr       : mark the destination register busy at issue
//   flush     : clear every busy bit (pipeline squash)
// ----------------------------------------------------------------------------
module regfile_mp_sb #(
    parameter int XLEN   = 64,
    parameter int ADDR_W = 5,
    parameter int NRD    = 2,
    parameter int BYPASS = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NRD*ADDR_W-1:0] rs_addr,
    output logic [NRD*XLEN-1:0]   rs_data,
    output logic [NRD-1:0]        rs_busy,
    input  logic                  wa_en,
    input  logic [ADDR_W-1:0]     wa_addr,
    input  logic [XLEN-1:0]       wa_data,
    input  logic                  wb_en,
    input  logic [ADDR_W-1:0]     wb_addr,
    input  logic [XLEN-1:0]       wb_data,
    input  logic                  rsv_en,
    input  logic [ADDR_W-1:0]     rsv_addr,
    input  logic                  flush
);

    localparam int NREGS = 2 ** ADDR_W;

    logic [XLEN-1:0]  regs_q [NREGS];
    logic [XLEN-1:0]  regs_d [NREGS];
    logic [NREGS-1:0] busy_q;
    logic [NREGS-1:0] busy_d;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: every variable written here first gets a full default, so no
        // path leaves it unassigned and no latch is inferred.
        regs_d = regs_q;
        busy_d = busy_q;

        // Port A is applied first and port B second. When both ports target
        // the same address, B's value overwrites A's.
        if (wa_en && (wa_addr != '0)) begin
            regs_d[wa_addr] = wa_data;
        end
        if (wb_en && (wb_addr != '0)) begin
            regs_d[wb_addr] = wb_data;
        end

        // Write-back clears the reservation. A reservation made in the same
        // cycle is applied afterwards, so it wins: a new producer is in flight.
        if (wa_en) begin
            busy_d[wa_addr] = 1'b0;
        end
        if (wb_en) begin
            busy_d[wb_addr] = 1'b0;
        end
        if (flush) begin
            busy_d = '0;
        end else if (rsv_en && (rsv_addr != '0)) begin
            busy_d[rsv_addr] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments in clocked blocks, so all flops
        // update together from the values present before the edge.
        if (rst) begin
            // NOTE: the register array is deliberately reset. After reset,
            // reads must return zero, so this is a flop array and not a
            // RAM macro.
            regs_q <= '{default: '0};
            busy_q <= '0;
        end else begin
            regs_q <= regs_d;
            busy_q <= busy_d;
        end
    end

    // ------------------------------------------------------------------
    // Read ports
    // ------------------------------------------------------------------
    for (genvar i = 0; i < NRD; i++) begin : g_rd
        logic [ADDR_W-1:0] addr;
        logic              hit_a;
        logic              hit_b;

        assign addr = rs_addr[i*ADDR_W +: ADDR_W];

        // A forwarding hit needs BYPASS, an enabled write and a matching,
        // non-zero address.
        assign hit_b = (BYPASS != 0) && wb_en && (wb_addr == addr) && (addr != '0);
        assign hit_a = (BYPASS != 0) && wa_en && (wa_addr == addr) && (addr != '0);

        assign rs_data[i*XLEN +: XLEN] = (addr == '0) ? '0      :
                                         hit_b        ? wb_data :
                                         hit_a        ? wa_data :
                                                        regs_q[addr];

        // Forwarded data is already valid, so the reader must not stall on it.
        assign rs_busy[i] = (hit_a || hit_b) ? 1'b0 : busy_q[addr];
    end

endmodule
